// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory, redirect and decode handshakes
// of the instruction-fetch front end.
interface fetch_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic [CW-1:0]   occupancy;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output dec_valid,
    output dec_inst,
    output dec_pc,
    output occupancy,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  dec_valid,
    input  dec_inst,
    input  dec_pc,
    input  occupancy,
    output dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, credit-limited imem requests and a
// DEPTH-entry {pc, inst} queue feeding decode.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [31:0]     inst_q [DEPTH];

  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] credit;
  logic [CW-1:0] rsp_dec;

  // Handshake qualifiers; redirect blocks both request and pop
  always_comb begin
    credit = outstanding + count;
    rsp_dec = CW'(bus.imem_rsp_valid);
    bus.imem_req_valid = !reset && (credit < FULL)
                         && !bus.redirect_valid;
    bus.imem_req_addr = fetch_pc;
    bus.dec_valid = (count != '0) && !bus.redirect_valid;
    req_fire = bus.imem_req_valid && bus.imem_req_ready;
    pop = bus.dec_valid && bus.dec_ready;
    push = bus.imem_rsp_valid && (discard == '0)
           && !bus.redirect_valid;
  end

  // Head entry is zero while empty so stale slots never show
  always_comb begin
    bus.dec_inst = '0;
    bus.dec_pc = '0;
    bus.occupancy = count;
    if (count != '0) begin
      bus.dec_inst = inst_q[head];
      bus.dec_pc = pc_q[head];
    end
  end

  // PCs, credit counters and queue pointers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      rsp_pc <= bus.redirect_pc;
      outstanding <= outstanding - rsp_dec;
      discard <= outstanding - rsp_dec;
      count <= '0;
      head <= tail;
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + STEP;
      outstanding <= outstanding + CW'(req_fire) - rsp_dec;
      if (bus.imem_rsp_valid && discard != '0)
        discard <= discard - CW'(1);
      if (push) begin
        tail <= tail + AW'(1);
        rsp_pc <= rsp_pc + STEP;
      end
      if (pop)
        head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage, written on a kept response
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[tail] <= rsp_pc;
      inst_q[tail] <= bus.imem_rsp_data;
    end
  end

  // Memory must never answer a request that was not issued
  always_ff @(posedge clock) begin
    if (!reset && bus.imem_rsp_valid)
      assert (outstanding != '0);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks plus a stream scoreboard
// against a latency-L memory model.
module tb_fetch_unit;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus();

  fetch_unit #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } ev_t;

  ev_t mq[$];
  ev_t acc_log[$];
  ev_t pop_log[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] exp_fetch;
  logic [31:0] exp_dec;

  function automatic logic [31:0] minst(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic run_cycles();
    forever begin
      @(posedge clock);
      cyc++;
    end
  endtask

  task automatic run_memory();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    forever begin
      @(posedge clock);
      #2;
      bus.imem_rsp_valid = 1'b0;
      if (reset) begin
        mq.delete();
      end else if (mq.size() != 0 && mq[0].cyc + lat <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = minst(mq[0].addr);
        void'(mq.pop_front());
      end
    end
  endtask

  task automatic run_monitor();
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_fetch = RESET_PC;
        exp_dec = RESET_PC;
      end else if (bus.redirect_valid) begin
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.dec_valid !== 1'b0) begin
          errors++;
          $display("FAIL redirect_gate: req_valid=%b dec_valid=%b need 0 0",
                   bus.imem_req_valid, bus.dec_valid);
        end
        exp_fetch = bus.redirect_pc;
        exp_dec = bus.redirect_pc;
      end else begin
        checks++;
        if (int'(bus.occupancy) + mq.size() > DEPTH) begin
          errors++;
          $display("FAIL credit: occ=%0d inflight=%0d limit %0d",
                   bus.occupancy, mq.size(), DEPTH);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          checks++;
          if (bus.imem_req_addr !== exp_fetch) begin
            errors++;
            $display("FAIL req_addr: got %h need %h",
                     bus.imem_req_addr, exp_fetch);
          end
          mq.push_back('{bus.imem_req_addr, cyc});
          acc_log.push_back('{bus.imem_req_addr, cyc});
          exp_fetch = exp_fetch + 32'd4;
        end
        if (bus.dec_valid && bus.dec_ready) begin
          checks++;
          if (bus.dec_pc !== exp_dec || bus.dec_inst !== minst(exp_dec)) begin
            errors++;
            $display("FAIL dec_stream: pc %h inst %h need pc %h inst %h",
                     bus.dec_pc, bus.dec_inst, exp_dec, minst(exp_dec));
          end
          pop_log.push_back('{bus.dec_pc, cyc});
          exp_dec = exp_dec + 32'd4;
        end
      end
    end
  endtask

  task automatic do_reset(input int l, input logic drdy);
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready = drdy;
    lat = l;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_valid: got %b need 0", bus.imem_req_valid);
    end
    checks++;
    if (bus.dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_dec_valid: got %b need 0", bus.dec_valid);
    end
    checks++;
    if (bus.occupancy !== '0) begin
      errors++;
      $display("FAIL rst_occ: got %0d need 0", bus.occupancy);
    end
    checks++;
    if (bus.imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rst_addr: got %h need %h", bus.imem_req_addr, RESET_PC);
    end
    checks++;
    if (bus.dec_inst !== 32'h0 || bus.dec_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_dec_data: inst %h pc %h need 0 0",
               bus.dec_inst, bus.dec_pc);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rst_first_req: valid %b addr %h need 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_streaming();
    int a0;
    int p0;
    int c0;
    do_reset(1, 1'b1);
    a0 = acc_log.size();
    p0 = pop_log.size();
    c0 = cyc;
    repeat (10) begin
      @(negedge clock);
      checks++;
      if (bus.occupancy > 1) begin
        errors++;
        $display("FAIL stream_occ: got %0d need <=1", bus.occupancy);
      end
    end
    #1;
    checks++;
    if (acc_log.size() < a0 + 3 || pop_log.size() < p0 + 6) begin
      errors++;
      $display("FAIL stream_len: acc %0d pop %0d need >=3 >=6",
               acc_log.size() - a0, pop_log.size() - p0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_log[a0+i].addr !== 32'(4 * i) || acc_log[a0+i].cyc != c0 + i) begin
          errors++;
          $display("FAIL stream_req%0d: addr %h cyc %0d need %h %0d", i,
                   acc_log[a0+i].addr, acc_log[a0+i].cyc, 4 * i, c0 + i);
        end
      end
      checks++;
      if (pop_log[p0].addr !== 32'h0 || pop_log[p0].cyc != c0 + 2) begin
        errors++;
        $display("FAIL stream_first_pop: pc %h cyc %0d need 0 %0d",
                 pop_log[p0].addr, pop_log[p0].cyc, c0 + 2);
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (pop_log[p0+i].cyc != c0 + 2 + i) begin
          errors++;
          $display("FAIL stream_rate%0d: cyc %0d need %0d", i,
                   pop_log[p0+i].cyc, c0 + 2 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int a0;
    int p0;
    do_reset(1, 1'b0);
    a0 = acc_log.size();
    p0 = pop_log.size();
    repeat (8) @(negedge clock);
    checks++;
    if (bus.occupancy !== 3'd4) begin
      errors++;
      $display("FAIL bp_occ: got %0d need 4", bus.occupancy);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0 || mq.size() != 0) begin
      errors++;
      $display("FAIL bp_credit: req_valid %b inflight %0d need 0 0",
               bus.imem_req_valid, mq.size());
    end
    @(posedge clock);
    #1;
    bus.dec_ready = 1'b1;
    repeat (8) @(negedge clock);
    #1;
    checks++;
    if (pop_log.size() < p0 + 4 || acc_log.size() < a0 + 5) begin
      errors++;
      $display("FAIL bp_len: pop %0d acc %0d need >=4 >=5",
               pop_log.size() - p0, acc_log.size() - a0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_log[p0+i].addr !== 32'(4 * i)) begin
          errors++;
          $display("FAIL bp_drain%0d: pc %h need %h", i,
                   pop_log[p0+i].addr, 4 * i);
        end
      end
      checks++;
      if (acc_log[a0+4].addr !== 32'h10) begin
        errors++;
        $display("FAIL bp_resume: addr %h need 00000010", acc_log[a0+4].addr);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    int r;
    int k;
    do_reset(3, 1'b1);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    r = cyc;
    @(negedge clock);
    checks++;
    if (mq.size() != 2) begin
      errors++;
      $display("FAIL rdi_inflight: got %0d need 2", mq.size());
    end
    @(posedge clock);
    #1;
    bus.redirect_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL rdi_addr: valid %b addr %h need 1 00000100",
               bus.imem_req_valid, bus.imem_req_addr);
    end
    repeat (10) @(negedge clock);
    #1;
    k = -1;
    for (int i = 0; i < pop_log.size(); i++)
      if (k < 0 && pop_log[i].cyc > r) k = i;
    checks++;
    if (k < 0) begin
      errors++;
      $display("FAIL rdi_pop: got none need pc 00000100");
    end else if (pop_log[k].addr !== 32'h100 || pop_log[k].cyc != r + 5) begin
      errors++;
      $display("FAIL rdi_pop: pc %h cyc %0d need 00000100 %0d",
               pop_log[k].addr, pop_log[k].cyc, r + 5);
    end
  endtask

  task automatic test_redirect_coincident();
    int r;
    int n;
    int k;
    do_reset(2, 1'b1);
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    r = cyc;
    @(negedge clock);
    n = pop_log.size();
    checks++;
    if (bus.imem_rsp_valid !== 1'b1 || bus.occupancy !== 3'd1) begin
      errors++;
      $display("FAIL rdc_pre: rsp %b occ %0d need 1 1",
               bus.imem_rsp_valid, bus.occupancy);
    end
    checks++;
    if (bus.dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdc_no_pop: dec_valid %b need 0", bus.dec_valid);
    end
    @(posedge clock);
    #1;
    bus.redirect_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.occupancy !== '0) begin
      errors++;
      $display("FAIL rdc_occ: got %0d need 0", bus.occupancy);
    end
    repeat (8) @(negedge clock);
    #1;
    k = -1;
    for (int i = n; i < pop_log.size(); i++)
      if (k < 0) k = i;
    checks++;
    if (k < 0) begin
      errors++;
      $display("FAIL rdc_pop: got none need pc 00000200");
    end else if (pop_log[k].addr !== 32'h200 || pop_log[k].cyc != r + 4) begin
      errors++;
      $display("FAIL rdc_pop: pc %h cyc %0d need 00000200 %0d",
               pop_log[k].addr, pop_log[k].cyc, r + 4);
    end
  endtask

  task automatic test_mem_stall();
    int a0;
    int c1;
    do_reset(1, 1'b1);
    a0 = acc_log.size();
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    bus.imem_req_ready = 1'b0;
    repeat (5) begin
      @(negedge clock);
      checks++;
      if (bus.imem_req_addr !== 32'h8 || bus.imem_req_valid !== 1'b1
          || mq.size() != 0) begin
        errors++;
        $display("FAIL stall_hold: addr %h valid %b inflight %0d need 8 1 0",
                 bus.imem_req_addr, bus.imem_req_valid, mq.size());
      end
    end
    @(posedge clock);
    #1;
    bus.imem_req_ready = 1'b1;
    c1 = cyc;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (acc_log.size() < a0 + 4) begin
      errors++;
      $display("FAIL stall_len: acc %0d need >=4", acc_log.size() - a0);
    end else if (acc_log[a0+2].addr !== 32'h8 || acc_log[a0+2].cyc != c1
                 || acc_log[a0+3].addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_resume: %h@%0d %h need 8@%0d c",
               acc_log[a0+2].addr, acc_log[a0+2].cyc,
               acc_log[a0+3].addr, c1);
    end
  endtask

  task automatic test_reset_midstream();
    int t;
    do_reset(1, 1'b0);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (bus.occupancy != 3'd3 && t < 20);
    checks++;
    if (bus.occupancy != 3'd3) begin
      errors++;
      $display("FAIL mid_fill: occ %0d need 3", bus.occupancy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.occupancy !== '0
        || bus.imem_req_addr !== RESET_PC || bus.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: dv %b occ %0d addr %h rv %b need 0 0 %h 0",
               bus.dec_valid, bus.occupancy, bus.imem_req_addr,
               bus.imem_req_valid, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    int r;
    int k;
    do_reset(1, 1'b1);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFFFFFC;
    r = cyc;
    @(posedge clock);
    #1;
    bus.redirect_valid = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    k = -1;
    for (int i = 0; i < pop_log.size(); i++)
      if (k < 0 && pop_log[i].cyc > r) k = i;
    checks++;
    if (k < 0 || k + 1 >= pop_log.size()) begin
      errors++;
      $display("FAIL wrap_len: got too few pops need 2");
    end else if (pop_log[k].addr !== 32'hFFFFFFFC
                 || pop_log[k+1].addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: %h %h need fffffffc 00000000",
               pop_log[k].addr, pop_log[k+1].addr);
    end
  endtask

  task automatic test_random();
    int p0;
    for (int trial = 0; trial < 3; trial++) begin
      do_reset(int'($urandom_range(1, 3)), 1'b1);
      p0 = pop_log.size();
      for (int n = 0; n < 600; n++) begin
        @(posedge clock);
        #1;
        bus.imem_req_ready = ($urandom_range(0, 3) != 0);
        bus.dec_ready = ($urandom_range(0, 9) < 7);
        bus.redirect_valid = ($urandom_range(0, 19) == 0);
        bus.redirect_pc = $urandom & 32'hFFFFFFFC;
      end
      @(posedge clock);
      #1;
      bus.redirect_valid = 1'b0;
      checks++;
      if (pop_log.size() - p0 < 100) begin
        errors++;
        $display("FAIL rand_progress: pops %0d need >=100",
                 pop_log.size() - p0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.dec_ready = 1'b1;
    fork
      run_cycles();
      run_memory();
      run_monitor();
      begin
        #2_000_000;
        $display("FAIL timeout: run exceeded time budget");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_mem_stall();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RV32 pipeline, replacing the bare PC register and single-entry FD latch. It holds the fetch PC, issues requests to instruction memory through a valid/ready handshake, buffers returned instructions with their PCs in a DEPTH-entry queue, and hands them to decode through a second valid/ready handshake. An execute-stage redirect flushes the queue and discards in-flight responses. This lets decode stall and lets memory latency exceed one cycle.

## Interface
- XLEN, 32: PC/address width.
- DEPTH, 4: queue entries and maximum outstanding requests; power of two, at least 2.
- RESET_PC, 0: PC of the first fetch after reset.

- clock  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address; word aligned.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart at redirect_pc (from execute: taken branch, jal, jalr).
- redirect_pc  in  XLEN  restart address.
- dec_valid  out  1  queue head is valid.
- dec_ready  in  1  decode consumes the head.
- dec_inst  out  32  head instruction.
- dec_pc  out  XLEN  head PC.
- occupancy  out  $clog2(DEPTH)+1  number of valid queue entries.

## Operation
- State:
  - fetch_pc: next request address.
  - rsp_pc: PC of the next expected response.
  - outstanding: accepted requests not yet answered.
  - discard: responses still to drop.
  - A circular queue of {pc, inst} with head and tail pointers and a count.
- Request credit:
  - imem_req_valid = (outstanding + count < DEPTH) && !redirect_valid.
  - The check uses values before this cycle's pop, so the queue can never overflow.
  - No write-enable-when-full path is needed.
- Request accept (imem_req_valid && imem_req_ready):
  - outstanding += 1.
  - fetch_pc += 4.
  - imem_req_addr = fetch_pc, held stable while ready is low.
- Response handling:
  - A response decrements outstanding.
  - If discard > 0: the response is dropped and discard -= 1.
  - Otherwise: {rsp_pc, imem_rsp_data} is written at tail and rsp_pc += 4.
  - Simultaneous accept and response leave outstanding unchanged.
- Pop:
  - dec_valid = (count != 0) && !redirect_valid.
  - dec_valid && dec_ready advances head.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (priority over every other event):
  - Queue cleared: count = 0 and head = tail.
  - No request is issued and no pop occurs.
  - fetch_pc = redirect_pc and rsp_pc = redirect_pc.
  - discard = outstanding − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is dropped.
  - A redirect while discard > 0 recomputes discard the same way.
- Arithmetic:
  - All PC adds are modulo 2^XLEN; wrap from 0xFFFFFFFC to 0 is legal.
  - Queue pointers wrap modulo DEPTH.
  - A response with outstanding = 0 is a protocol violation; simulation asserts.
- Reset (asynchronous, any time):
  - fetch_pc = rsp_pc = RESET_PC.
  - outstanding = discard = count = 0, pointers = 0.
  - Outputs during and immediately after reset: imem_req_valid = 0 while reset is high, dec_valid = 0, occupancy = 0, imem_req_addr = RESET_PC.
  - dec_inst and dec_pc are 0 while the queue is empty after reset.
  - Instruction memory is reset with this block, so no stale responses arrive.

## Timing
- Request accepted in cycle N with memory latency L ≥ 1 (response in cycle N+L): the instruction is written at the end of N+L, and dec_valid is high from cycle N+L+1.
- First request after reset is presented in the first cycle reset is low.
- Sustained throughput is 1 instruction/cycle when DEPTH ≥ L+2, dec_ready = 1 and imem_req_ready = 1.
- Redirect asserted in cycle R:
  - Cycle R: dec_valid = 0 and imem_req_valid = 0.
  - Cycle R+1: imem_req_addr = redirect_pc.
  - Earliest correct-path dec_valid is cycle R+L+2.
- dec_inst, dec_pc and occupancy are registered-state outputs (no combinational path from imem_rsp); only the valid gating by redirect_valid is combinational.

## Test plan
- Streaming, reset release, L=1, DEPTH=4, ready always high:
  - Requests 0x0, 0x4, 0x8 in consecutive cycles from the first cycle after reset.
  - dec_pc 0x0 appears two cycles after the first request, then one new PC every cycle.
  - occupancy stays ≤ 1.
- Decode backpressure, dec_ready=0, L=1:
  - After four responses, occupancy = 4, outstanding = 0 and imem_req_valid = 0.
  - Raising dec_ready drains PCs 0x0–0xC in order, and fetching resumes at 0x10.
- Redirect with two responses in flight, L=3, redirect to 0x100:
  - Both late responses are dropped.
  - The next dec_pc = 0x100 with the data returned for address 0x100.
  - No wrong-path entry reaches decode.
- Redirect coincident with a response and with dec_valid && dec_ready:
  - No pop occurs and the arriving response is dropped.
  - occupancy = 0 in the next cycle.
  - discard equals the remaining outstanding count.
- Memory stall:
  - imem_req_ready=0 for 5 cycles: imem_req_addr is held (e.g. 0x8) and outstanding is unchanged.
  - Fetch continues at 0x8 then 0xC after ready rises.
- Reset mid-stream (queue holding 3 entries) and PC wrap:
  - On reset: dec_valid = 0, occupancy = 0, imem_req_addr = RESET_PC immediately.
  - Separately, a redirect to 0xFFFFFFFC yields dec_pc 0xFFFFFFFC then 0x0.
